tone_sequencer: RTL and testbench

Autonomous note player that drives the freqgen peripheral over its write bus (fg_addr/fg_data/fg_we), so the CPU does not have to time each tone itself. The CPU loads a small note table: per entry a clock-divider select, a half-period and a duration. The CPU then issues start. The block steps through the table, programs freqgen for each note, holds it for the note's duration, and silences the output at the end or on stop. It sits on the CPU peripheral bus beside freqgen and shares freqgen's clk domain.

---
 rtl/tone_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Autonomous note player: walks a CPU-loaded note table and programs freqgen
// (divider select, half-period) over its register write bus, one note at a time.
module tone_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000,
  localparam int IW = $clog2(DEPTH),
  localparam int TW = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   addr,
  input  logic [15:0]   data,
  input  logic          we,
  output logic [1:0]    fg_addr,
  output logic [15:0]   fg_data,
  output logic          fg_we,
  output logic          busy,
  output logic [IW-1:0] cur_idx,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WDIV = 3'd2,
    WLIM = 3'd3,
    PLAY = 3'd4,
    SIL  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [15:0] per_mem [DEPTH];
  logic [4:0]  div_mem [DEPTH];
  logic [15:0] dur_mem [DEPTH];

  logic [IW-1:0] wptr;
  logic [IW:0]   len;
  logic          loop;

  // idx is one bit wider than a table index so "len reached" is visible at len == DEPTH
  logic [IW:0]   idx, idx_nx, idx_inc;
  logic [IW-1:0] rd;
  logic [15:0]   pdur, pdur_nx;
  logic [15:0]   dcnt, dcnt_nx;
  logic [TW-1:0] tick, tick_nx;

  logic          fg_we_nx;
  logic [1:0]    fg_addr_nx;
  logic [15:0]   fg_data_nx;
  logic          done_nx;

  logic [2:0]    reg_sel;
  logic          wr_ctrl;
  logic          start;
  logic          stop;
  logic [IW:0]   len_in;
  logic [IW:0]   len_clamped;
  logic          unused_bits;

  assign reg_sel     = addr[2:0];
  assign wr_ctrl     = we && (reg_sel == 3'd0);
  assign start       = wr_ctrl && data[0];
  assign stop        = wr_ctrl && data[1];
  assign len_in      = data[IW:0];
  assign rd          = idx[IW-1:0];
  assign idx_inc     = idx + {{IW{1'b0}}, 1'b1};
  assign cur_idx     = idx[IW-1:0];
  assign unused_bits = ^addr[15:3];

  // LEN writes above the table size saturate at DEPTH
  always_comb begin
    len_clamped = len_in;
    if (len_in > (IW+1)'(DEPTH)) begin
      len_clamped = (IW+1)'(DEPTH);
    end else begin
      len_clamped = len_in;
    end
  end

  // CPU-visible control registers: write pointer, length, loop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= {IW{1'b0}};
      len  <= {(IW+1){1'b0}};
      loop <= 1'b0;
    end else if (we) begin
      case (reg_sel)
        3'd0:    loop <= data[2];
        3'd1:    len  <= len_clamped;
        3'd2:    wptr <= data[IW-1:0];
        3'd5:    wptr <= wptr + {{(IW-1){1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

  // Note table storage; contents are undefined after reset
  always_ff @(posedge clk) begin
    if (we) begin
      case (reg_sel)
        3'd3:    per_mem[wptr] <= data;
        3'd4:    div_mem[wptr] <= data[4:0];
        3'd5:    dur_mem[wptr] <= data;
        default: ;
      endcase
    end
  end

  // Sequencer next state; fg_* are computed one cycle early so they register in step with the state
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pdur_nx    = pdur;
    dcnt_nx    = dcnt;
    tick_nx    = tick;
    fg_we_nx   = 1'b0;
    fg_addr_nx = 2'd0;
    fg_data_nx = 16'd0;
    done_nx    = 1'b0;

    if (stop) begin
      state_nx   = SIL;
      fg_we_nx   = 1'b1;
      fg_addr_nx = 2'd3;
      fg_data_nx = 16'd0;
      done_nx    = 1'b1;
    end else if (start) begin
      state_nx = LOAD;
      idx_nx   = {(IW+1){1'b0}};
    end else begin
      case (state)
        IDLE: begin
          state_nx = IDLE;
        end
        LOAD: begin
          if (idx >= len) begin
            if (loop) begin
              idx_nx = {(IW+1){1'b0}};
            end else begin
              state_nx   = SIL;
              fg_we_nx   = 1'b1;
              fg_addr_nx = 2'd3;
              fg_data_nx = 16'd0;
              done_nx    = 1'b1;
            end
          end else if (dur_mem[rd] == 16'd0) begin
            idx_nx = idx_inc;
          end else begin
            state_nx   = WDIV;
            pdur_nx    = dur_mem[rd];
            fg_we_nx   = 1'b1;
            fg_addr_nx = 2'd0;
            fg_data_nx = {11'd0, div_mem[rd]};
          end
        end
        WDIV: begin
          state_nx   = WLIM;
          fg_we_nx   = 1'b1;
          fg_addr_nx = 2'd3;
          fg_data_nx = per_mem[rd];
        end
        WLIM: begin
          state_nx = PLAY;
          tick_nx  = {TW{1'b0}};
          dcnt_nx  = 16'd0;
        end
        PLAY: begin
          if (tick == TW'(TICK_DIV - 1)) begin
            tick_nx = {TW{1'b0}};
            if (dcnt == (pdur - 16'd1)) begin
              state_nx = LOAD;
              // wrap straight to entry 0 so looping costs no extra LOAD cycle
              if (loop && (idx_inc >= len)) begin
                idx_nx = {(IW+1){1'b0}};
              end else begin
                idx_nx = idx_inc;
              end
            end else begin
              dcnt_nx = dcnt + 16'd1;
            end
          end else begin
            tick_nx = tick + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        SIL: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= {(IW+1){1'b0}};
      pdur    <= 16'd0;
      dcnt    <= 16'd0;
      tick    <= {TW{1'b0}};
      fg_we   <= 1'b0;
      fg_addr <= 2'd0;
      fg_data <= 16'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      pdur    <= pdur_nx;
      dcnt    <= dcnt_nx;
      tick    <= tick_nx;
      fg_we   <= fg_we_nx;
      fg_addr <= fg_addr_nx;
      fg_data <= fg_data_nx;
      done    <= done_nx;
      busy    <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: freqgen writes and done pulses are
// scoreboarded against expected (addr, data, cycle) entries.
module tb_tone_sequencer;
  localparam int DEPTH = 16;
  localparam int TD    = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] data = 16'd0;
  logic        we   = 1'b0;
  logic [1:0]  fg_addr;
  logic [15:0] fg_data;
  logic        fg_we;
  logic        busy;
  logic [3:0]  cur_idx;
  logic        done;

  tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .we(we),
    .fg_addr(fg_addr), .fg_data(fg_data), .fg_we(fg_we),
    .busy(busy), .cur_idx(cur_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [4:0]  div;
    logic [15:0] per;
    logic [15:0] dur;
    int          sil;   // cycles from LOAD entry to silence write
    int          idle;  // cycles from LOAD entry to busy low
  } vec_t;

  wr_t wq[$];
  int  dq[$];
  wr_t mon_e;
  int  mon_d;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every freqgen write and done pulse must match the next expectation
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (fg_we === 1'b1) begin
        if (wq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, none expected", fg_addr, fg_data, cyc);
        end else begin
          mon_e = wq.pop_front();
          chk("wr_addr", fg_addr, mon_e.a);
          chk("wr_data", fg_data, mon_e.d);
          chk("wr_cycle", cyc, mon_e.c);
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
        end else begin
          mon_d = dq.pop_front();
          chk("done_cycle", cyc, mon_d);
        end
      end
    end
  end

  task automatic push_wr(input logic [1:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    wq.push_back(e);
  endtask

  // Drive a write; p is the cycle in which the FSM first reacts (LOAD/SIL)
  task automatic drive(input logic [2:0] a, input logic [15:0] d, output int p);
    @(negedge clk);
    addr = {13'd0, a};
    data = d;
    we   = 1'b1;
    p    = cyc + 1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    we   = 1'b0;
    addr = 16'd0;
    data = 16'd0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    int p;
    drive(a, d, p);
    release_bus();
  endtask

  task automatic load_note(input logic [4:0] div, input logic [15:0] per, input logic [15:0] dur);
    bus_write(3'd3, per);
    bus_write(3'd4, {11'd0, div});
    bus_write(3'd5, dur);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int exp_c, input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, cyc, exp_c);
  endtask

  task automatic check_drained();
    chk("pending_writes", wq.size(), 0);
    chk("pending_done", dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int p, q, r;

    vecs[0] = '{div: 5'd3,  per: 16'd100,   dur: 16'd2, sil: 12, idle: 13};
    vecs[1] = '{div: 5'd31, per: 16'd0,     dur: 16'd1, sil: 8,  idle: 9};
    vecs[2] = '{div: 5'd0,  per: 16'hFFFF,  dur: 16'd3, sil: 16, idle: 17};
    vecs[3] = '{div: 5'd17, per: 16'h1234,  dur: 16'd1, sil: 8,  idle: 9};

    repeat (3) @(negedge clk);
    chk("rst_fg_we", fg_we, 0);
    chk("rst_fg_addr", fg_addr, 0);
    chk("rst_fg_data", fg_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_idx", cur_idx, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-note vectors
    bus_write(3'd1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      bus_write(3'd2, 16'd0);
      load_note(vecs[i].div, vecs[i].per, vecs[i].dur);
      drive(3'd0, 16'd1, p);
      push_wr(2'd0, {11'd0, vecs[i].div}, p + 1);
      push_wr(2'd3, vecs[i].per, p + 2);
      push_wr(2'd3, 16'd0, p + vecs[i].sil);
      dq.push_back(p + vecs[i].sil);
      release_bus();
      chk("busy_rise", busy, 1);
      wait_idle(p + vecs[i].idle, "busy_fall");
      check_drained();
    end

    // Looping two-entry table: note period 7 cycles, no done until stopped
    bus_write(3'd2, 16'd0);
    load_note(5'd1, 16'd50, 16'd1);
    load_note(5'd2, 16'd0, 16'd1);
    bus_write(3'd1, 16'd2);
    drive(3'd0, 16'd5, p);
    for (int n = 0; n < 2; n++) begin
      push_wr(2'd0, 16'd1, p + 1 + 14*n);
      push_wr(2'd3, 16'd50, p + 2 + 14*n);
      push_wr(2'd0, 16'd2, p + 8 + 14*n);
      push_wr(2'd3, 16'd0, p + 9 + 14*n);
    end
    release_bus();
    wait_until(p + 24);
    drive(3'd0, 16'd2, q);
    push_wr(2'd3, 16'd0, q);
    dq.push_back(q);
    release_bus();
    wait_idle(q + 1, "loop_stop_idle");
    check_drained();

    // Zero-duration middle entry is skipped
    bus_write(3'd2, 16'd0);
    load_note(5'd4, 16'd10, 16'd1);
    load_note(5'd5, 16'd20, 16'd0);
    load_note(5'd6, 16'd30, 16'd1);
    bus_write(3'd1, 16'd3);
    drive(3'd0, 16'd1, p);
    push_wr(2'd0, 16'd4, p + 1);
    push_wr(2'd3, 16'd10, p + 2);
    push_wr(2'd0, 16'd6, p + 9);
    push_wr(2'd3, 16'd30, p + 10);
    push_wr(2'd3, 16'd0, p + 16);
    dq.push_back(p + 16);
    release_bus();
    wait_until(p + 9);
    chk("skip_cur_idx", cur_idx, 2);
    wait_idle(p + 17, "skip_idle");
    check_drained();

    // Stop during PLAY of entry 1
    bus_write(3'd2, 16'd0);
    load_note(5'd1, 16'd11, 16'd1);
    load_note(5'd2, 16'd22, 16'd2);
    load_note(5'd3, 16'd33, 16'd1);
    load_note(5'd4, 16'd44, 16'd1);
    bus_write(3'd1, 16'd4);
    drive(3'd0, 16'd1, p);
    push_wr(2'd0, 16'd1, p + 1);
    push_wr(2'd3, 16'd11, p + 2);
    push_wr(2'd0, 16'd2, p + 8);
    push_wr(2'd3, 16'd22, p + 9);
    release_bus();
    wait_until(p + 10);
    chk("play_cur_idx", cur_idx, 1);
    drive(3'd0, 16'd2, q);
    push_wr(2'd3, 16'd0, q);
    dq.push_back(q);
    release_bus();
    wait_idle(q + 1, "stop_idle");
    repeat (20) @(negedge clk);
    check_drained();

    // Restart while entry 2 plays, then start+stop together
    drive(3'd0, 16'd1, p);
    push_wr(2'd0, 16'd1, p + 1);
    push_wr(2'd3, 16'd11, p + 2);
    push_wr(2'd0, 16'd2, p + 8);
    push_wr(2'd3, 16'd22, p + 9);
    push_wr(2'd0, 16'd3, p + 19);
    push_wr(2'd3, 16'd33, p + 20);
    release_bus();
    wait_until(p + 20);
    drive(3'd0, 16'd1, q);
    push_wr(2'd0, 16'd1, q + 1);
    push_wr(2'd3, 16'd11, q + 2);
    release_bus();
    chk("restart_busy", busy, 1);
    wait_until(q + 2);
    drive(3'd0, 16'd3, r);
    push_wr(2'd3, 16'd0, r);
    dq.push_back(r);
    release_bus();
    wait_idle(r + 1, "startstop_idle");
    check_drained();

    // Empty table: immediate silence
    bus_write(3'd1, 16'd0);
    drive(3'd0, 16'd1, p);
    push_wr(2'd3, 16'd0, p + 1);
    dq.push_back(p + 1);
    release_bus();
    chk("len0_busy", busy, 1);
    wait_idle(p + 2, "len0_idle");
    check_drained();

    // Stop while idle still forces a silence write
    drive(3'd0, 16'd2, p);
    push_wr(2'd3, 16'd0, p);
    dq.push_back(p);
    release_bus();
    wait_idle(p + 1, "idle_stop_idle");
    check_drained();

    // LEN=20 clamps to 16 entries
    bus_write(3'd2, 16'd0);
    for (int i = 0; i < 16; i++) begin
      load_note(5'(i), 16'(100 + i), 16'd1);
    end
    bus_write(3'd1, 16'd20);
    drive(3'd0, 16'd1, p);
    for (int i = 0; i < 16; i++) begin
      push_wr(2'd0, 16'(i), p + 1 + 7*i);
      push_wr(2'd3, 16'(100 + i), p + 2 + 7*i);
    end
    push_wr(2'd3, 16'd0, p + 113);
    dq.push_back(p + 113);
    release_bus();
    wait_idle(p + 114, "clamp_idle");
    check_drained();

    // Asynchronous reset in the middle of the limit write
    bus_write(3'd2, 16'd0);
    load_note(5'd7, 16'd77, 16'd2);
    bus_write(3'd1, 16'd1);
    drive(3'd0, 16'd1, p);
    push_wr(2'd0, 16'd7, p + 1);
    push_wr(2'd3, 16'd77, p + 2);
    release_bus();
    wait_until(p + 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_fg_we", fg_we, 0);
    chk("arst_fg_addr", fg_addr, 0);
    chk("arst_fg_data", fg_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cur_idx", cur_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_drained();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
